ps2_rx_controller: RTL and testbench
====================================

// Module: ps2_rx_controller
//
// PURPOSE
//   Receive-only PS/2 keyboard host interface. Samples the open-drain PS2_CLK/PS2_DAT
//   lines, decodes device-to-host 11-bit frames and presents each valid scan-code byte
//   with a one-cycle strobe. Sits between the board PS/2 pins and keyboard decode logic
//   (make/break 0xF0, extended 0xE0 handling lives downstream).
//
// PARAMETERS
//   TIMEOUT_CYCLES  100000  idle cycles (2 ms @ 50 MHz) between clock edges before an open frame is abandoned
//
// PORTS
//   CLOCK_50           in     1  system clock, 50 MHz; the only clock
//   reset_n            in     1  asynchronous, active-low reset (board KEY[0] directly)
//   PS2_CLK            inout  1  PS/2 clock, open-drain; never driven by this block (always 'z')
//   PS2_DAT            inout  1  PS/2 data, open-drain; never driven by this block (always 'z')
//   received_data      out    8  last valid byte, held until the next valid frame
//   received_data_en   out    1  one-cycle pulse: received_data updated this cycle
//
// BEHAVIOUR
//   - Reset (async, reset_n=0): received_data=8'h00, received_data_en=0, FSM=IDLE,
//     bit counter=0, shift reg=0, timeout counter=0, sync flops=1 (bus idle high).
//   - Sync: PS2_CLK and PS2_DAT each pass 2 flops (s1,s2); third flop clk_s3 on clock.
//     fall = clk_s3 & ~clk_s2 (combinational). Data sampled from dat_s2 when fall=1.
//   - Frame (LSB first, sampled on PS2_CLK falling edges): start(0), d0..d7, odd parity, stop(1).
//   - FSM: IDLE: on fall with dat=0 -> DATA (bit count 0); fall with dat=1 ignored.
//     DATA: 8 falls shift dat into bit[count]; after 8th -> PARITY.
//     PARITY: on fall store parity bit -> STOP.
//     STOP: on fall: if dat=1 and ^{data,parity}==1 -> load received_data, pulse en; -> IDLE
//     in all cases. Bad parity or stop=0: frame dropped, no pulse, received_data unchanged.
//   - Latency: en is high on the 3rd CLOCK_50 rising edge after PS2_CLK falls for the
//     stop bit (2 sync + 1 register), exactly one cycle wide.
//   - Timeout: outside IDLE, counter increments each cycle and clears on every fall; on
//     reaching TIMEOUT_CYCLES -> IDLE, partial data discarded, no pulse. Counter held 0 in IDLE.
//   - Back-to-back frames: a fall in the same cycle STOP completes cannot occur (bus
//     timing); next start bit accepted from the cycle after return to IDLE.
//   - Reset mid-frame: immediate abort; first frame after release must begin with a start bit.
//   - Glitches shorter than 1 cycle are not filtered; no debounce required.
//
// STRUCTURE
//   - Package ps2_pkg: FRAME_BITS=11, DATA_BITS=8, state enum {IDLE,DATA,PARITY,STOP},
//     scan-code constants BREAK=8'hF0, EXTEND=8'hE0 (shared with downstream decode).
//   - Sub-module ps2_line_sync: 2-flop synchronizer + third flop + falling-edge flag for
//     PS2_CLK, 2-flop sync for PS2_DAT; instantiated once. Top holds FSM, shift reg, timeout.
//
// TESTING (bit period 2000 cycles = 40 us, data changes mid-high phase)
//   1 Reset: hold reset_n=0, lines high -> data=8'h00, en=0; release, 10k idle cycles -> no en.
//   2 Valid frame 0x16 (3 ones, parity=0, stop=1) -> exactly one en pulse, data=8'h16,
//     en on 3rd clock edge after stop-bit PS2_CLK fall.
//   3 Sequence 0xF0 (parity=1) then 0x16 -> two pulses, data 8'hF0 then 8'h16, held between.
//   4 Frame 0x1C sent with parity=1 (wrong) -> no pulse, data keeps previous value;
//     next good 0x1C frame -> pulse, data=8'h1C.
//   5 Stop bit 0 on 0x25 -> no pulse; start-bit-only then lines idle 100000 cycles -> timeout
//     to IDLE; following valid 0x2E frame -> pulse, data=8'h2E.
//   6 reset_n asserted after 4 data bits, released, full 0x3D frame -> one pulse, data=8'h3D;
//     PS2_CLK/PS2_DAT observed 'z' from this block throughout.

Source files
------------

// File: rtl/ps2_rx_controller_pkg.sv
// Shared PS/2 receive definitions: frame geometry, receiver states and the
// scan-code prefixes that downstream keyboard decode also relies on.
package ps2_pkg;

    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] BREAK  = 8'hF0;
    localparam logic [7:0] EXTEND = 8'hE0;

    // Odd parity over the data byte plus its parity bit must come out as 1.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_rx_controller_if.sv
// Received-byte output bundle: byte value plus one-cycle update strobe.
interface ps2_rx_if;

    logic [7:0] received_data;
    logic       received_data_en;

    modport master (output received_data, output received_data_en);
    modport slave  (input  received_data, input  received_data_en);

endinterface

// File: rtl/ps2_rx_controller_line_sync.sv
// Brings the asynchronous PS/2 lines into the CLOCK_50 domain and flags
// PS2_CLK falling edges. Flops reset to 1 because the idle bus is high.
module ps2_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk_in,
    input  logic ps2_dat_in,
    output logic clk_fall,
    output logic dat_sync
);

    logic clk_s1_q, clk_s2_q, clk_s3_q;
    logic dat_s1_q, dat_s2_q;
    logic clk_s1_d, clk_s2_d, clk_s3_d;
    logic dat_s1_d, dat_s2_d;

    // Next-state for the synchronizer chains.
    always_comb begin
        clk_s1_d = ps2_clk_in;
        clk_s2_d = clk_s1_q;
        clk_s3_d = clk_s2_q;
        dat_s1_d = ps2_dat_in;
        dat_s2_d = dat_s1_q;
    end

    // Synchronizer registers, idle-high after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            clk_s3_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= clk_s1_d;
            clk_s2_q <= clk_s2_d;
            clk_s3_q <= clk_s3_d;
            dat_s1_q <= dat_s1_d;
            dat_s2_q <= dat_s2_d;
        end
    end

    assign clk_fall = clk_s3_q & ~clk_s2_q;
    assign dat_sync = dat_s2_q;

endmodule

// File: rtl/ps2_rx_controller.sv
// Receive-only PS/2 host: decodes device-to-host 11-bit frames and presents
// each good scan-code byte with a one-cycle strobe. Never drives the bus.
module ps2_rx_controller
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic     CLOCK_50,
    input  logic     reset_n,
    inout  wire      PS2_CLK,
    inout  wire      PS2_DAT,
    ps2_rx_if.master rx
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    LAST_BIT   = 3'(DATA_BITS - 1);

    assign PS2_CLK = 1'bz;
    assign PS2_DAT = 1'bz;

    logic fall;
    logic dat;

    ps2_line_sync u_sync (
        .clk       (CLOCK_50),
        .rst_n     (reset_n),
        .ps2_clk_in(PS2_CLK),
        .ps2_dat_in(PS2_DAT),
        .clk_fall  (fall),
        .dat_sync  (dat)
    );

    ps2_state_e    state_q,  state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q,  shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] timer_q,  timer_d;
    logic [7:0]    data_q,   data_d;
    logic          en_q,     en_d;

    // Frame decode FSM with inter-edge timeout that abandons stalled frames.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        timer_d   = timer_q;
        data_d    = data_q;
        en_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (fall && !dat) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d[bit_cnt_q] = dat;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    parity_d = dat;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    if (dat && odd_parity_ok(shift_q, parity_q)) begin
                        data_d = shift_q;
                        en_d   = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Timer only runs inside a frame; an expiry overrides any progress.
        if (state_q == IDLE) begin
            timer_d = '0;
        end else if (fall) begin
            timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
            timer_d = '0;
            state_d = IDLE;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Receiver state registers.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            timer_q   <= '0;
            data_q    <= '0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            timer_q   <= timer_d;
            data_q    <= data_d;
            en_q      <= en_d;
        end
    end

    assign rx.received_data    = data_q;
    assign rx.received_data_en = en_q;

endmodule

// File: tb/tb_ps2_rx_controller.sv
// Bench for ps2_rx_controller: drives PS/2 frames, scoreboards the bytes and
// checks strobe latency, hold behaviour, timeout and mid-frame reset.
module tb_ps2_rx_controller;
    import ps2_pkg::*;

    localparam int unsigned TO = 500;
    localparam int unsigned Q  = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clk_drv = 1'b1;
    logic dat_drv = 1'b1;
    wire  ps2_clk_w;
    wire  ps2_dat_w;

    assign ps2_clk_w = clk_drv;
    assign ps2_dat_w = dat_drv;

    always #10 clk = ~clk;

    ps2_rx_if rx ();

    ps2_rx_controller #(.TIMEOUT_CYCLES(TO)) dut (
        .CLOCK_50(clk),
        .reset_n (rst_n),
        .PS2_CLK (ps2_clk_w),
        .PS2_DAT (ps2_dat_w),
        .rx      (rx)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  last_good = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Scoreboard: every strobe must match the oldest expected byte.
    always @(posedge clk) begin
        #1;
        if (rx.received_data_en === 1'b1) begin
            if (exp_q.size() == 0) check_eq("spurious_en", 32'd1, 32'd0);
            else check_eq("sb_data", 32'(rx.received_data), 32'(exp_q.pop_front()));
        end
    end

    // One PS/2 bit: data changes mid-high, then a low phase.
    task automatic ps2_bit(input logic b);
        repeat (Q) @(negedge clk);
        dat_drv = b;
        repeat (Q) @(negedge clk);
        clk_drv = 1'b0;
        repeat (2 * Q) @(negedge clk);
        clk_drv = 1'b1;
    endtask

    task automatic send_partial(input logic [7:0] d, input int nbits);
        ps2_bit(1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(d[i]);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop,
                              input int pause_after, input int unsigned pause_len);
        logic par;
        logic valid;
        par   = ~(^d) ^ bad_par;
        valid = !bad_par && stop;
        if (valid) exp_q.push_back(d);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            ps2_bit(d[i]);
            if (i == pause_after) repeat (pause_len) @(negedge clk);
        end
        ps2_bit(par);
        repeat (Q) @(negedge clk);
        dat_drv = stop;
        repeat (Q) @(negedge clk);
        clk_drv = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("en_lat%0d_%02h", k, d), 32'(rx.received_data_en),
                     32'(k == 3 && valid));
        end
        if (valid) last_good = d;
        check_eq($sformatf("data_after_%02h", d), 32'(rx.received_data), 32'(last_good));
        repeat (2 * Q - 4) @(negedge clk);
        clk_drv = 1'b1;
        dat_drv = 1'b1;
        repeat (4 * Q) @(negedge clk);
    endtask

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and quiet idle bus.
        repeat (5) @(negedge clk);
        check_eq("rst_data", 32'(rx.received_data), 32'h00);
        check_eq("rst_en", 32'(rx.received_data_en), 32'd0);
        rst_n = 1'b1;
        repeat (1000) @(negedge clk);
        check_eq("idle_data", 32'(rx.received_data), 32'h00);

        // Single valid frame, then a two-frame sequence with hold check.
        send_frame(8'h16, 1'b0, 1'b1, -1, 0);
        send_frame(BREAK, 1'b0, 1'b1, -1, 0);
        send_frame(8'h16, 1'b0, 1'b1, -1, 0);
        repeat (200) @(negedge clk);
        check_eq("hold_16", 32'(rx.received_data), 32'h16);

        // Bad parity dropped, then the good frame.
        send_frame(8'h1C, 1'b1, 1'b1, -1, 0);
        send_frame(8'h1C, 1'b0, 1'b1, -1, 0);

        // Bad stop bit dropped.
        send_frame(8'h25, 1'b0, 1'b0, -1, 0);
        check_eq("hold_1c", 32'(rx.received_data), 32'h1C);

        // Start bit only, bus stalls past the timeout, then a full frame.
        send_partial(8'h00, 0);
        repeat (TO + 100) @(negedge clk);
        send_frame(8'h2E, 1'b0, 1'b1, -1, 0);

        // Long stall still inside the timeout keeps the frame alive.
        send_frame(8'hE0, 1'b0, 1'b1, 2, TO - 100);

        // Reset mid-frame, then a full frame after release.
        send_partial(8'h3D, 4);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("midrst_data", 32'(rx.received_data), 32'h00);
        check_eq("midrst_en", 32'(rx.received_data_en), 32'd0);
        last_good = 8'h00;
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        send_frame(8'h3D, 1'b0, 1'b1, -1, 0);

        repeat (50) @(negedge clk);
        check_eq("final_data", 32'(rx.received_data), 32'h3D);
        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
